// File: rtl/stick_round_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stick_round_sequencer_pkg
//  Purpose  : Shared types, state encoding and geometry constants for the
//             stick-game round sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package stick_round_sequencer_pkg;

    typedef logic [9:0]  coord_t;   // on-screen coordinate / length
    typedef logic [10:0] wide_t;    // one extra bit so sums never wrap
    typedef logic [2:0]  state_t;

    // Round state encoding (also exported to the renderer as state_o)
    localparam state_t c_IDLE    = 3'd0;
    localparam state_t c_READY   = 3'd1;
    localparam state_t c_GROW    = 3'd2;
    localparam state_t c_JUDGE   = 3'd3;
    localparam state_t c_ANIM    = 3'd4;
    localparam state_t c_ADVANCE = 3'd5;
    localparam state_t c_OVER    = 3'd6;

    // Screen geometry, hCount/vCount units
    localparam int c_X_MIN    = 144;
    localparam int c_X_MAX    = 784;
    localparam int c_PLAT_Y   = 515;
    localparam int c_ANCHOR_X = 400;

    // Platform layout restored on reset and on restart after game over
    localparam coord_t c_RST_CURR_X = 10'd200;
    localparam coord_t c_RST_CURR_W = 10'd200;
    localparam coord_t c_RST_NEXT_X = 10'd500;
    localparam coord_t c_RST_NEXT_W = 10'd200;

endpackage : stick_round_sequencer_pkg
`default_nettype wire

// File: rtl/stick_round_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : stick_round_sequencer_if
//  Purpose  : Player inputs, renderer handshake and game-state bus between
//             the round sequencer (master) and the renderer side (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface stick_round_sequencer_if;
    import stick_round_sequencer_pkg::*;

    logic        tick;
    logic        btn_up;
    logic        anim_ack;
    logic        anim_req;
    logic        anim_kind;
    coord_t      anim_dist;
    coord_t      stick_len;
    coord_t      curr_x;
    coord_t      curr_w;
    coord_t      next_x;
    coord_t      next_w;
    logic [3:0]  score_tens;
    logic [3:0]  score_ones;
    logic        hit;
    logic        game_over;
    state_t      state_o;

    modport master (
        input  tick, btn_up, anim_ack,
        output anim_req, anim_kind, anim_dist, stick_len,
               curr_x, curr_w, next_x, next_w,
               score_tens, score_ones, hit, game_over, state_o
    );

    modport slave (
        output tick, btn_up, anim_ack,
        input  anim_req, anim_kind, anim_dist, stick_len,
               curr_x, curr_w, next_x, next_w,
               score_tens, score_ones, hit, game_over, state_o
    );

endinterface : stick_round_sequencer_if
`default_nettype wire

// File: rtl/stick_round_sequencer_plat_lfsr.sv
`default_nettype none
// ============================================================================
//  Module   : plat_lfsr
//  Purpose  : Free-running 16-bit Galois LFSR feeding platform generation.
//             Steps every clock so results depend on player timing.
//  Revision : 1.0  initial release
// ============================================================================
module plat_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1,   // must be non-zero
    parameter logic [15:0] TAPS = 16'hB400
)(
    input  wire logic       clk,
    input  wire logic       rst_n,
    output logic [7:0]      o_rnd_w,     // width field, lfsr[7:0]
    output logic [6:0]      o_rnd_gap    // gap field,   lfsr[14:8]
);

    logic [15:0] r_lfsr;

    // Shift right, folding the tap mask in when a one falls out of bit 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? TAPS : 16'h0000);
        end
    end

    assign o_rnd_w   = r_lfsr[7:0];
    assign o_rnd_gap = r_lfsr[14:8];

endmodule : plat_lfsr
`default_nettype wire

// File: rtl/stick_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : stick_round_sequencer
//  Purpose  : Round scheduler for the stick game: waits for a press, grows
//             the stick, judges the landing, hands one walk/fall job to the
//             renderer, then scores and generates the next platform.
//  Revision : 1.0  initial release
// ============================================================================
module stick_round_sequencer
    import stick_round_sequencer_pkg::*;
#(
    parameter int          X_MIN     = c_X_MIN,
    parameter int          ANCHOR_X  = c_ANCHOR_X,
    parameter int          STICK_MAX = 400,
    parameter int          GROW_STEP = 1,
    parameter int          W_MIN     = 20,
    parameter int          GAP_MIN   = 35,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
)(
    input  wire logic               clk,
    input  wire logic               rst_n,
    stick_round_sequencer_if.master bus
);

    state_t     r_state, w_next_state;
    coord_t     r_stick, r_cx, r_cw, r_nx, r_nw;
    logic       r_anim_req, r_anim_kind;
    coord_t     r_anim_dist;
    logic [3:0] r_tens, r_ones, w_tens_new, w_ones_new;
    logic [1:0] w_shift;
    logic [7:0] w_rnd_w;
    logic [6:0] w_rnd_gap;

    wide_t      w_tip, w_gap, w_stick_w, w_reach, w_stick_inc;
    logic       w_hit_c, w_grow_tick, w_restart;
    coord_t     w_walk_dist, w_stick_next, w_nw_new, w_nx_new, w_cx_new;

    plat_lfsr #(
        .SEED      (LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .o_rnd_w   (w_rnd_w),
        .o_rnd_gap (w_rnd_gap)
    );

    // Landing judgement in 11-bit arithmetic; walk distance = gap + next_w
    assign w_tip       = {1'b0, r_cx} + {1'b0, r_cw};
    assign w_gap       = {1'b0, r_nx} - w_tip;
    assign w_stick_w   = {1'b0, r_stick};
    assign w_reach     = w_gap + {1'b0, r_nw};
    assign w_hit_c     = (w_gap <= w_stick_w) && (w_stick_w <= w_reach);
    assign w_walk_dist = coord_t'(w_reach);

    assign w_stick_inc  = w_stick_w + wide_t'(GROW_STEP);
    assign w_stick_next = (w_stick_inc > wide_t'(STICK_MAX)) ? coord_t'(STICK_MAX)
                                                              : coord_t'(w_stick_inc);

    assign w_grow_tick = (r_state == c_GROW) && bus.tick && bus.btn_up;
    assign w_restart   = (r_state == c_OVER) && bus.tick && bus.btn_up;

    // BCD increment saturating at 99, plus difficulty shift from the new tens
    always_comb begin
        w_tens_new = r_tens;
        w_ones_new = r_ones;
        if (!(r_tens == 4'd9 && r_ones == 4'd9)) begin
            if (r_ones == 4'd9) begin
                w_ones_new = 4'd0;
                w_tens_new = r_tens + 4'd1;
            end else begin
                w_ones_new = r_ones + 4'd1;
            end
        end
        if (w_tens_new >= 4'd2)      w_shift = 2'd3;
        else if (w_tens_new == 4'd1) w_shift = 2'd2;
        else                         w_shift = 2'd1;
    end

    // Next platform geometry; the new current platform ends at the anchor
    assign w_nw_new = coord_t'(W_MIN) + {2'b00, (w_rnd_w >> w_shift)};
    assign w_nx_new = coord_t'(ANCHOR_X + GAP_MIN) + {3'b000, w_rnd_gap};
    assign w_cx_new = (({1'b0, r_nw} + wide_t'(X_MIN)) > wide_t'(ANCHOR_X))
                      ? coord_t'(X_MIN) : (coord_t'(ANCHOR_X) - r_nw);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic; btn_up only matters in the player-paced states
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:    if (bus.tick && !bus.btn_up) w_next_state = c_READY;
            c_READY:   if (bus.tick &&  bus.btn_up) w_next_state = c_GROW;
            c_GROW:    if (bus.tick && !bus.btn_up) w_next_state = c_JUDGE;
            c_JUDGE:   w_next_state = c_ANIM;
            c_ANIM:    if (bus.anim_ack) w_next_state = r_anim_kind ? c_OVER : c_ADVANCE;
            c_ADVANCE: w_next_state = c_READY;
            c_OVER:    if (bus.tick &&  bus.btn_up) w_next_state = c_IDLE;
            default:   w_next_state = c_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        bus.hit       = (r_state == c_ADVANCE);
        bus.game_over = (r_state == c_OVER);
        bus.state_o   = r_state;
    end

    // Stick grows while held, cleared when a round is scored or the game restarts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stick <= '0;
        end else if (w_grow_tick) begin
            r_stick <= w_stick_next;
        end else if (r_state == c_ADVANCE || w_restart) begin
            r_stick <= '0;
        end
    end

    // Animation job: issued in JUDGE, held until the renderer acknowledges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_anim_req  <= 1'b0;
            r_anim_kind <= 1'b0;
            r_anim_dist <= '0;
        end else if (r_state == c_JUDGE) begin
            r_anim_req  <= 1'b1;
            r_anim_kind <= !w_hit_c;
            r_anim_dist <= w_hit_c ? w_walk_dist : r_stick;
        end else if (r_state == c_ANIM && bus.anim_ack) begin
            r_anim_req  <= 1'b0;
        end
    end

    // Platform geometry: shifts left on a hit, restored on restart
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cx <= c_RST_CURR_X;
            r_cw <= c_RST_CURR_W;
            r_nx <= c_RST_NEXT_X;
            r_nw <= c_RST_NEXT_W;
        end else if (r_state == c_ADVANCE) begin
            r_cx <= w_cx_new;
            r_cw <= r_nw;
            r_nx <= w_nx_new;
            r_nw <= w_nw_new;
        end else if (w_restart) begin
            r_cx <= c_RST_CURR_X;
            r_cw <= c_RST_CURR_W;
            r_nx <= c_RST_NEXT_X;
            r_nw <= c_RST_NEXT_W;
        end
    end

    // BCD score: +1 per hit, held through OVER for display, cleared on restart
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else if (r_state == c_ADVANCE) begin
            r_tens <= w_tens_new;
            r_ones <= w_ones_new;
        end else if (w_restart) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end
    end

    assign bus.anim_req   = r_anim_req;
    assign bus.anim_kind  = r_anim_kind;
    assign bus.anim_dist  = r_anim_dist;
    assign bus.stick_len  = r_stick;
    assign bus.curr_x     = r_cx;
    assign bus.curr_w     = r_cw;
    assign bus.next_x     = r_nx;
    assign bus.next_w     = r_nw;
    assign bus.score_tens = r_tens;
    assign bus.score_ones = r_ones;

endmodule : stick_round_sequencer
`default_nettype wire
